// File: rtl/dcache_refill_unit_pkg.sv
// Shared cache definitions: AXI encodings, refill FSM state encoding and
// the line/bank geometry defaults shared with the data and tag banks.
package dcache_refill_unit_pkg;

    // Cache geometry defaults
    localparam int LINE_WORDS_DEF = 8;
    localparam int OFF_W_DEF      = 3;
    localparam int RAM_AW_DEF     = 7;

    // AXI4 encodings used by the refill path
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
    localparam int         AXI_RESP_SLVERR = 1;   // rresp bit that flags SLVERR/DECERR

    // Refill FSM state encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_AR_ENC   = 2'd1;
    localparam logic [1:0] ST_R_ENC    = 2'd2;
    localparam logic [1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_AR   = ST_AR_ENC,
        ST_R    = ST_R_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/dcache_refill_unit.sv
// Line refill engine: takes a miss request, issues one AXI4 INCR read burst
// for the aligned line, writes every beat into the data bank and forwards
// the critical word to the pipeline as soon as it arrives.
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where
// both are high. A valid, once raised, stays high with stable payload until
// that edge; ready may depend on state but never on the partner's valid.
module dcache_refill_unit
    import dcache_refill_unit_pkg::*;
#(
    parameter int         LINE_WORDS = LINE_WORDS_DEF,
    parameter int         OFF_W      = OFF_W_DEF,
    parameter int         RAM_AW     = RAM_AW_DEF,
    parameter logic [3:0] ARID       = 4'd0
) (
    input  logic              clk,
    input  logic              resetn,
    // refill request from the miss handler
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    // AXI4 read address channel
    output logic [3:0]        arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    // AXI4 read data channel
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // data bank write port
    output logic [3:0]        ram_wea,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [31:0]       ram_dina,
    // pipeline side
    output logic              crit_valid,
    output logic [31:0]       crit_data,
    output logic              refill_done,
    output logic              refill_err,
    // FSM observation
    output state_t            dbg_state
);

    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);
    localparam int               IDX_W    = RAM_AW - OFF_W;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        line_addr;
    logic [OFF_W-1:0]   crit_off;
    logic [OFF_W-1:0]   beat_cnt;
    logic               err;

    logic               beat_fire;
    logic               last_beat;
    logic               beat_bad;
    logic [IDX_W-1:0]   line_idx;

    // rid is not checked (single outstanding burst); rresp[0] only
    // distinguishes EXOKAY, which is meaningless for a refill.
    logic               unused_inputs;
    assign unused_inputs = ^{rid, rresp[0]};

    assign beat_fire = (state == ST_R) && rvalid;
    assign last_beat = (beat_cnt == LAST_CNT);
    assign beat_bad  = rresp[AXI_RESP_SLVERR] || (rlast != last_beat);
    assign line_idx  = line_addr[RAM_AW+1:OFF_W+2];

    // State register plus request latch, beat counter and sticky error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            line_addr <= '0;
            crit_off  <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        line_addr <= {req_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        crit_off  <= req_addr[OFF_W+1:2];
                        beat_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end
                ST_R: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_bad) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state: the burst length is fixed by arlen, so the counter rather
    // than rlast decides when the line is complete.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid)              state_nxt = ST_AR;
            ST_AR:   if (arready)                state_nxt = ST_R;
            ST_R:    if (beat_fire && last_beat) state_nxt = ST_DONE;
            ST_DONE:                             state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Bank write and critical-word forward happen in the beat's own cycle
    always_comb begin
        ram_wea    = 4'h0;
        ram_waddr  = {line_idx, beat_cnt};
        ram_dina   = rdata;
        crit_valid = 1'b0;
        crit_data  = rdata;
        if (beat_fire) begin
            ram_wea    = 4'hF;
            crit_valid = (beat_cnt == crit_off);
        end
    end

    // Remaining outputs are pure decodes of registered state
    assign req_ready   = (state == ST_IDLE);
    assign arvalid     = (state == ST_AR);
    assign rready      = (state == ST_R);
    assign refill_done = (state == ST_DONE);
    assign refill_err  = (state == ST_DONE) && err;

    assign arid      = ARID;
    assign araddr    = line_addr;
    assign arlen     = 8'(LINE_WORDS - 1);
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;
    assign dbg_state = state;

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit: driver tasks push expected AR
// addresses, bank writes, critical words and done/error results into
// queues; a negedge monitor pops and compares whenever the DUT emits them.
module tb_dcache_refill_unit;
    import dcache_refill_unit_pkg::*;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'h3;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [3:0]  ram_wea;
    logic [6:0]  ram_waddr;
    logic [31:0] ram_dina;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        refill_done;
    logic        refill_err;
    state_t      dbg_state;

    dcache_refill_unit dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .ram_wea(ram_wea), .ram_waddr(ram_waddr), .ram_dina(ram_dina),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .refill_done(refill_done), .refill_err(refill_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    logic [31:0] ar_q[$];
    logic [38:0] wr_q[$];     // {waddr, data}
    logic [31:0] crit_q[$];
    logic        done_q[$];   // expected refill_err

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [31:0] m_ar;
    logic [38:0] m_wr;
    logic [31:0] m_crit;
    logic        m_done;

    always @(negedge clk) begin
        if (resetn) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else begin
                    m_ar = ar_q.pop_front();
                    check("araddr", araddr, m_ar);
                    check("arlen", arlen, 8'd7);
                    check("arsize", arsize, 3'd2);
                    check("arburst", arburst, 2'd1);
                    check("arid", arid, 4'd0);
                end
            end
            if (rvalid || ram_wea != 4'h0)
                check("ram_wea", ram_wea, (rvalid && rready) ? 4'hF : 4'h0);
            if (ram_wea != 4'h0) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    m_wr = wr_q.pop_front();
                    check("ram_waddr", ram_waddr, m_wr[38:32]);
                    check("ram_dina", ram_dina, m_wr[31:0]);
                end
            end
            if (crit_valid) begin
                if (crit_q.size() == 0) check("crit_unexpected", 1, 0);
                else begin
                    m_crit = crit_q.pop_front();
                    check("crit_data", crit_data, m_crit);
                end
            end
            if (refill_done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    m_done = done_q.pop_front();
                    check("refill_err", refill_err, m_done);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One refill. Beat indices are 0-based; -1 disables err/rst options.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] exp_line,
                             input logic [6:0] wbase, input int crit,
                             input logic [31:0] dbase, input int ar_stall,
                             input bit gaps, input int err_beat, input int rlast_beat,
                             input int rst_beat, input bit exp_err, input bit chk_lat);
        int n;
        int unsigned hs;
        int unsigned dcyc;
        bit found;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = addr;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", req_ready, 1);
        ar_q.push_back(exp_line);
        @(posedge clk); #1;
        hs = cyc;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        check("state_after_req", dbg_state, ST_AR);
        check("req_ready_busy", req_ready, 0);

        // address phase, optionally stalled with a junk rvalid on the bus
        arready = 1'b0;
        rvalid  = (ar_stall > 0);
        rdata   = 32'hDEAD_BEEF;
        for (int k = 0; k < ar_stall; k++) begin
            @(negedge clk);
            check("arvalid_hold", arvalid, 1);
            check("araddr_hold", araddr, exp_line);
            check("rready_in_ar", rready, 0);
            @(posedge clk); #1;
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;

        // data phase
        for (int i = 0; i < LW; i++) begin
            if (gaps && i > 0) begin
                rvalid = 1'b0;
                @(posedge clk); #1;
            end
            rvalid = 1'b1;
            rdata  = dbase + 32'(i);
            rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            rlast  = (i == rlast_beat);
            if (i == rst_beat) begin
                resetn = 1'b0;
                @(negedge clk);
                check("rst_arvalid", arvalid, 0);
                check("rst_rready", rready, 0);
                check("rst_wea", ram_wea, 0);
                check("rst_crit", crit_valid, 0);
                check("rst_done", refill_done, 0);
                check("rst_err", refill_err, 0);
                check("rst_state", dbg_state, ST_IDLE);
                rvalid = 1'b0;
                rlast  = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                #1;
                check("rst_req_ready", req_ready, 1);
                return;
            end
            wr_q.push_back({wbase + 7'(i), dbase + 32'(i)});
            if (i == crit) crit_q.push_back(dbase + 32'(i));
            @(negedge clk);
            check("rready_in_r", rready, 1);
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        done_q.push_back(exp_err);

        found = 1'b0;
        dcyc  = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (refill_done) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
        check("done_seen", found, 1);
        // done is raised by the 9th edge after the request edge, i.e. it is
        // high during cycle 2+LINE_WORDS counted from the handshake
        if (chk_lat) check("done_latency", dcyc - hs, LW + 1);
        @(posedge clk); #1;
        check("idle_after_done", dbg_state, ST_IDLE);
        check("req_ready_after_done", req_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        check("reset_arvalid", arvalid, 0);
        check("reset_rready", rready, 0);
        check("reset_wea", ram_wea, 0);
        check("reset_done", refill_done, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_crit", crit_valid, 0);
        check("reset_err", refill_err, 0);

        // unloaded refill with latency check
        do_refill(32'h0000_1234, 32'h0000_1220, 7'h08, 5, 32'hA0, 0, 0, -1, 7, -1, 0, 1);
        // AR stalled five cycles, critical word on the last beat
        do_refill(32'h0000_0FFC, 32'h0000_0FE0, 7'h78, 7, 32'h100, 5, 0, -1, 7, -1, 0, 0);
        // idle cycle between every beat, critical word on the first beat
        do_refill(32'h8000_0040, 32'h8000_0040, 7'h10, 0, 32'h200, 0, 1, -1, 7, -1, 0, 0);
        // SLVERR on the third beat
        do_refill(32'h0000_01A8, 32'h0000_01A0, 7'h68, 2, 32'h300, 0, 0, 2, 7, -1, 1, 0);
        // rlast on the fifth beat, burst still runs to eight
        do_refill(32'h0000_0100, 32'h0000_0100, 7'h40, 0, 32'h400, 0, 0, -1, 4, -1, 1, 0);
        // reset during the fourth beat
        do_refill(32'h0000_0074, 32'h0000_0060, 7'h18, 5, 32'h500, 0, 0, -1, 7, 3, 0, 0);
        // normal refill after the reset
        do_refill(32'h2000_0058, 32'h2000_0040, 7'h10, 6, 32'h600, 0, 0, -1, 7, -1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("ar_q_empty", ar_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("crit_q_empty", crit_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
